ex_result_stage: RTL
====================

// Module: ex_result_stage
// PURPOSE
// - EX->MEM pipeline stage directly downstream of the ALU.
// - Captures ALU result/flags with instruction sideband and resolves conditional branches.
// - Emits a one-cycle redirect to fetch on a taken branch.
// - 2-entry skid buffer: full throughput while the memory stage back-pressures via out_ready.
// PARAMETERS
// XLEN      32  datapath width (result, store data, PC)
// RA_W      5   destination register index width
// PORTS
// clk             in   1     rising-edge clock
// reset           in   1     asynchronous, active-high reset
// flush           in   1     kill all held entries and the current input
// in_valid        in   1     ALU outputs + sideband valid this cycle
// in_ready        out  1     stage can accept (entries held < 2)
// alu_result      in   XLEN  ALU regD
// alu_zero        in   1     ALU zero flag
// alu_lt/alu_gt   in   1     ALU unsigned compare flags
// br_type         in   3     0 none,1 BEQ,2 BNE,3 BLT,4 BGE,5 JUMP, 6-7 none
// br_target       in   XLEN  branch/jump target PC
// store_data      in   XLEN  regB pass-through for stores
// rd              in   RA_W  destination register
// reg_write,mem_read,mem_write in 1 control sideband
// out_valid       out  1     head entry valid toward MEM
// out_ready       in   1     MEM accepts head entry
// out_result,out_store_data out XLEN; out_rd out RA_W; out_reg_write,out_mem_read,out_mem_write out 1
// redirect_valid  out  1     one-cycle pulse: taken branch/jump
// redirect_pc     out  XLEN  target for the redirect
// BEHAVIOUR
// - Reset: all outputs 0, both entries empty, in_ready=1 on the first cycle after reset deassert.
// - Occupancy states:
//   - EMPTY: in_ready=1, out_valid=0.
//   - ONE: in_ready=1, out_valid=1.
//   - FULL: in_ready=0, out_valid=1.
// - Transfers: accept = in_valid&in_ready; pop = out_valid&out_ready.
//   - EMPTY: +accept -> ONE.
//   - ONE: accept&!pop -> FULL; pop&!accept -> EMPTY; accept&pop -> ONE (new data becomes head).
//   - FULL: pop -> ONE (skid entry moves to head; no accept since in_ready=0).
// - in_ready is registered from occupancy only, never combinational from out_ready.
// - Latency: accepted in cycle N -> out_valid in cycle N+1 when the stage was EMPTY.
// - Order is strictly FIFO. Outputs are stable while out_valid&!out_ready.
// - Branch condition is evaluated on accept. ALU is driven with SUB for branches; zero means equal.
//   - BEQ: zero.
//   - BNE: !zero.
//   - BLT: lt&!zero.
//   - BGE: zero|gt. lt/gt are not trusted when zero=1.
//   - JUMP: always taken. br_type 0/6/7: never taken.
// - Taken: redirect_valid=1 and redirect_pc=br_target in cycle N+1 for exactly one cycle.
//   - redirect_pc holds its last value otherwise.
//   - Branches still enter the buffer; their reg_write/mem_* are passed through unchanged.
// - flush: next cycle EMPTY, out_valid=0, redirect_valid=0; the same-cycle input is dropped.
//   - flush has priority over accept, pop and redirect.
// - reset mid-operation: immediate clear, no partial entry or redirect visible.
// - out_* data fields are don't-care when out_valid=0.
// TESTING
// - Single ADD, out_ready=1: alu_result=0x0000_0005, rd=3, reg_write=1 -> next cycle out_valid=1, out_result=5, out_rd=3, redirect_valid=0.
// - Back-pressure: out_ready=0, push A,B -> in_ready=0 after B; raise out_ready -> A then B on consecutive cycles, unchanged values, no loss.
// - BLT with zero=1, lt=1 (stale) -> not taken; BNE with zero=0 -> redirect_valid one cycle, redirect_pc=br_target=0x0000_0040.
// - Simultaneous accept+pop in ONE: continuous stream of 8 ops, out_ready=1 -> one result per cycle, in_ready stays 1.
// - FULL + flush while in_valid=1 with a taken JUMP -> next cycle out_valid=0, in_ready=1, redirect_valid=0.
// - Reset asserted while FULL and redirect pending -> outputs 0 asynchronously; after release the first accepted op exits with latency 1.

Source files
------------

// File: rtl/ex_result_stage.sv
// EX->MEM result stage: captures ALU output and sideband into a 2-entry skid buffer
// and resolves conditional branches into a one-cycle fetch redirect.
//
// state | meaning
// EMPTY | no entries held; in_ready=1, out_valid=0
// ONE   | head entry valid; in_ready=1, out_valid=1
// FULL  | head and skid entries valid; in_ready=0, out_valid=1
module ex_result_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            alu_gt,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] store_data,
    input  logic [RA_W-1:0] rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } entry_t;

    state_t state, state_nxt;
    entry_t head, skid, in_entry;
    logic   in_ready_q;
    logic   accept, pop, taken;
    logic   load_head_in, load_head_skid, load_skid;

    assign in_entry = '{result: alu_result, store_data: store_data, rd: rd,
                        reg_write: reg_write, mem_read: mem_read, mem_write: mem_write};

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // ALU runs SUB for branches; lt/gt are unreliable when the operands are equal.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            3'd1:    taken = alu_zero;
            3'd2:    taken = ~alu_zero;
            3'd3:    taken = alu_lt & ~alu_zero;
            3'd4:    taken = alu_zero | alu_gt;
            3'd5:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready comes from a register so it never depends on out_ready in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in)
                head <= in_entry;
            else if (load_head_skid)
                head <= skid;
            if (load_skid)
                skid <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken & ~flush;
            if (accept && taken && !flush)
                redirect_pc <= br_target;
        end
    end

    assign out_result     = head.result;
    assign out_store_data = head.store_data;
    assign out_rd         = head.rd;
    assign out_reg_write  = head.reg_write;
    assign out_mem_read   = head.mem_read;
    assign out_mem_write  = head.mem_write;

endmodule
